branch_ctrl: RTL
================

# branch_ctrl

Branch-resolution controller for the EX stage of the 5-stage RV32I pipeline. It drives the comparator with the decoded branch condition, computes the control-transfer target and issues a valid/ready redirect to fetch. While the redirect is outstanding it squashes the IF/ID and ID/EX registers. It also flags misaligned targets and keeps two wrapping event counters.

## Interface
- XLEN, 32, datapath width
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- ex_valid_i  in  1  EX stage holds a valid instruction
- ex_kind_i  in  br_kind_t  BR_NONE / BR_COND / BR_JAL / BR_JALR
- ex_cmp_op_i  in  cmp_op_t  branch condition; used only for BR_COND
- ex_pc_i  in  XLEN  PC of the EX instruction
- ex_imm_i  in  XLEN  sign-extended immediate
- ex_rs1_i, ex_rs2_i  in  XLEN  forwarded operands
- fetch_ready_i  in  1  fetch accepts the redirect
- redirect_valid_o  out  1  redirect request, registered
- redirect_pc_o  out  XLEN  redirect target, registered
- flush_if_id_o  out  1  squash the IF/ID register
- flush_id_ex_o  out  1  squash the ID/EX register
- misalign_o  out  1  one-cycle pulse when a target has bit 1 set
- cond_cnt_o  out  32  count of evaluated BR_COND instructions
- redirect_cnt_o  out  32  count of accepted redirects

## Operation
- Branch fire condition `fire` = ex_valid_i & state==IDLE & (kind==BR_JAL | kind==BR_JALR | (kind==BR_COND & branch_taken)).
  - branch_taken comes from the CMP instance, fed ex_cmp_op_i, ex_rs1_i and ex_rs2_i.
- Target computation, modulo 2^XLEN:
  - BR_COND and BR_JAL: ex_pc_i + ex_imm_i.
  - BR_JALR: (ex_rs1_i + ex_imm_i) & ~1.
- Misaligned target: if `fire` and target[1]==1, then misalign_o=1 in the next cycle. No redirect and no flush are issued, and the state stays IDLE.
- FSM states: IDLE and REDIRECT.
  - IDLE to REDIRECT: on `fire` with an aligned target. In the same cycle, assert flush_if_id_o=1 and flush_id_ex_o=1 combinationally and latch the target.
  - REDIRECT: redirect_valid_o=1 and redirect_pc_o=latched target; both flush outputs stay 1 every cycle.
  - REDIRECT to IDLE: on the cycle where fetch_ready_i=1. This is the handshake cycle; flushes are still asserted in it.
  - In REDIRECT, ex_valid_i is ignored: no evaluation, no counting.
  - In IDLE, fetch_ready_i is ignored.
- Counters:
  - cond_cnt_o increments on every IDLE cycle with ex_valid_i & kind==BR_COND, whether taken or not.
  - redirect_cnt_o increments on every handshake cycle.
  - Both wrap 0xFFFFFFFF to 0.
- BR_NONE or ex_valid_i=0 in IDLE: no outputs asserted.

## Timing
- Reset: state=IDLE; redirect_valid_o=0, redirect_pc_o=0, misalign_o=0, both counters 0. Flushes are 0 because they are decoded from the state.
- Reset during REDIRECT: the request is dropped immediately (asynchronous). Fetch sees no handshake.
- Latencies, with `fire` in cycle T:
  - flushes asserted in cycle T.
  - redirect_valid_o first high in cycle T+1.
  - earliest handshake at T+1; earliest next `fire` at T+2.
- redirect_pc_o holds stable while redirect_valid_o=1 and fetch_ready_i=0. It keeps its last value after the handshake.
- misalign_o is registered: high exactly in cycle T+1.

## Structure
- Shared package `defs`:
  - br_kind_t, a 2-bit enum.
  - br_state_t (IDLE, REDIRECT).
  - cmp_op_t and data_t, reused.
- Sub-module: CMP, instantiated once with XLEN passed through.
- Contents of branch_ctrl itself:
  - FSM register.
  - Target register.
  - Misalign register.
  - Two counters.
  - Combinational target adder and fire logic.

## Test plan
- **Taken BEQ:** BR_COND BEQ, rs1=rs2=5, pc=0x100, imm=0x20 at T.
  - Required: flushes=1 at T; redirect_valid_o=1 and redirect_pc_o=0x120 at T+1.
  - With fetch_ready_i=1 at T+1: IDLE at T+2, redirect_cnt_o=1, cond_cnt_o=1.
- **Signed vs unsigned compare:** rs1=0xFFFFFFFF, rs2=1.
  - BLT: redirect issued.
  - BLTU: no redirect, no flush, cond_cnt_o still increments.
- **Backpressure:** JAL pc=0x200, imm=-8.
  - fetch_ready_i low for 3 cycles: redirect_pc_o=0x1F8 held stable and flushes stay high for all 4 REDIRECT cycles.
  - An ex_valid_i BR_COND injected during REDIRECT is not counted.
- **JALR masking and misalignment:**
  - rs1=0x1001, imm=1: target 0x1002 gives misalign_o=1 at T+1 and no redirect.
  - rs1=0x1001, imm=3: target 0x1004 is redirected.
- **Reset mid-operation:** assert rst_i during REDIRECT.
  - Required: redirect_valid_o=0 and flushes=0 immediately; counters 0; state IDLE after release.
- **Counter wrap:** force redirect_cnt_o to 0xFFFFFFFF, then complete one handshake.
  - Required: redirect_cnt_o reads 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared types for the EX-stage branch-resolution controller.
//   XLEN       : datapath width
//   data_t     : XLEN-wide datapath word
//   br_kind_t  : control-transfer class decoded in ID
//   cmp_op_t   : branch condition, encoded as the RV32I funct3 of the branch
//   br_state_t : redirect FSM state
//   redirect_t : fetch redirect request (valid + target)
package branch_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_kind_t;

  // funct3 encoding lets decode pass the instruction field straight through.
  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BNE  = 3'b001,
    CMP_BLT  = 3'b100,
    CMP_BGE  = 3'b101,
    CMP_BLTU = 3'b110,
    CMP_BGEU = 3'b111
  } cmp_op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } br_state_t;

  typedef struct packed {
    logic  valid;
    data_t pc;
  } redirect_t;

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Branch comparator: evaluates the RV32I branch condition on two operands.
//   op    : branch condition
//   a, b  : forwarded rs1 / rs2 values
//   taken : condition holds (0 for unassigned funct3 codes)
import branch_ctrl_pkg::*;

module branch_ctrl_cmp #(
  parameter int XLEN = 32
) (
  input  cmp_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  logic eq, lt_s, lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    taken = 1'b0;
    case (op)
      CMP_BEQ:  taken = eq;
      CMP_BNE:  taken = !eq;
      CMP_BLT:  taken = lt_s;
      CMP_BGE:  taken = !lt_s;
      CMP_BLTU: taken = lt_u;
      CMP_BGEU: taken = !lt_u;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch-resolution controller.
// Resolves conditional branches and jumps, computes the target, and hands a
// valid/ready redirect to fetch. While a redirect is pending (and in the cycle
// that launches it) the IF/ID and ID/EX registers are squashed. Targets with
// bit 1 set raise a one-cycle misalign pulse instead of redirecting.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   ex_valid_i            : EX holds a valid instruction
//   ex_kind_i/ex_cmp_op_i : transfer class and branch condition
//   ex_pc_i, ex_imm_i     : instruction PC and sign-extended immediate
//   ex_rs1_i, ex_rs2_i    : forwarded operands
//   fetch_ready_i         : fetch accepts the redirect
//   redirect_valid_o/pc_o : registered redirect request to fetch
//   flush_if_id_o/id_ex_o : squash younger pipeline registers
//   misalign_o            : registered misaligned-target pulse
//   cond_cnt_o            : evaluated conditional branches (wrapping)
//   redirect_cnt_o        : accepted redirects (wrapping)
import branch_ctrl_pkg::*;

module branch_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  br_kind_t        ex_kind_i,
  input  cmp_op_t         ex_cmp_op_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic            fetch_ready_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_if_id_o,
  output logic            flush_id_ex_o,
  output logic            misalign_o,
  output logic [31:0]     cond_cnt_o,
  output logic [31:0]     redirect_cnt_o
);

  br_state_t       state;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            misalign_q;
  logic [31:0]     cond_cnt_q;
  logic [31:0]     redirect_cnt_q;

  logic            taken;
  logic            is_jump;
  logic            fire;
  logic            launch;
  logic            handshake;
  logic            count_cond;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target;

  branch_ctrl_cmp #(.XLEN(XLEN)) u_cmp (
    .op    (ex_cmp_op_i),
    .a     (ex_rs1_i),
    .b     (ex_rs2_i),
    .taken (taken)
  );

  // One adder serves all kinds: JALR adds to rs1, everything else to the PC.
  assign base   = (ex_kind_i == BR_JALR) ? ex_rs1_i : ex_pc_i;
  assign sum    = base + ex_imm_i;
  assign target = (ex_kind_i == BR_JALR) ? {sum[XLEN-1:1], 1'b0} : sum;

  assign is_jump = (ex_kind_i == BR_JAL) || (ex_kind_i == BR_JALR);

  // EX is only evaluated in IDLE; a pending redirect owns the stage.
  assign fire = ex_valid_i && (state == IDLE) &&
                (is_jump || ((ex_kind_i == BR_COND) && taken));

  // Bit 1 set means the target is not 4-byte aligned: flag it, do not redirect.
  assign launch    = fire && !target[1];
  assign handshake = (state == REDIRECT) && fetch_ready_i;
  assign count_cond = ex_valid_i && (state == IDLE) && (ex_kind_i == BR_COND);

  // Flushes go out combinationally in the launch cycle so the wrong-path
  // instructions behind the branch never advance.
  assign flush_if_id_o = launch || (state == REDIRECT);
  assign flush_id_ex_o = launch || (state == REDIRECT);

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign misalign_o       = misalign_q;
  assign cond_cnt_o       = cond_cnt_q;
  assign redirect_cnt_o   = redirect_cnt_q;

  // Redirect FSM with registered outputs. The target register is only
  // written on launch, so it is stable under backpressure and keeps its
  // value after the handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misalign_q       <= 1'b0;
    end else begin
      misalign_q <= fire && target[1];
      case (state)
        IDLE: begin
          if (launch) begin
            state            <= REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target;
          end
        end
        REDIRECT: begin
          if (fetch_ready_i) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Event counters, free-running and wrapping at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cond_cnt_q     <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (count_cond) cond_cnt_q     <= cond_cnt_q + 32'd1;
      if (handshake)  redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

endmodule
